// File: rtl/serial_magnitude_comparator_ctrl_if.sv
// Bundle of the request-side handshake and the external comparator slice
// connection for serial_magnitude_comparator_ctrl.
//   start/a/b        : request pulse and operands from the requesting unit
//   busy/done/EQ/GT  : status and registered result back to the requester
//   slice_a/b/eq/gt  : digit and cascade inputs driven onto the slice
//   slice_EQ/GT      : combinational cascade outputs returned by the slice
// master = requester + slice side, slave = the sequencer.
interface serial_magnitude_comparator_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             EQ;
  logic             GT;
  logic [1:0]       slice_a;
  logic [1:0]       slice_b;
  logic             slice_eq;
  logic             slice_gt;
  logic             slice_EQ;
  logic             slice_GT;

  modport master (
    output start, a, b, slice_EQ, slice_GT,
    input  busy, done, EQ, GT, slice_a, slice_b, slice_eq, slice_gt
  );

  modport slave (
    input  start, a, b, slice_EQ, slice_GT,
    output busy, done, EQ, GT, slice_a, slice_b, slice_eq, slice_gt
  );
endinterface

// File: rtl/serial_magnitude_comparator_ctrl.sv
// Serial magnitude comparator sequencer. Walks two WIDTH-bit unsigned
// operands MSB first, 2 bits per digit, through one external combinational
// 2-bit cascadable comparator slice. Each digit is held on the slice for
// SETTLE_CYCLES clocks, then the slice's EQ/GT are captured and fed back as
// the next digit's cascade inputs. Stops early once eq drops.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_magnitude_comparator_ctrl_if (handshake,
//           registered result, slice drive and slice return)
module serial_magnitude_comparator_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  serial_magnitude_comparator_ctrl_if.slave bus
);
  localparam int D  = WIDTH / 2;
  localparam int DW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [DW-1:0] DIG_INIT = DW'(D - 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic             r_eq;
  logic             r_gt;
  logic [DW-1:0]    r_dig;
  logic [CW-1:0]    r_cnt;
  logic             r_EQ;
  logic             r_GT;

  logic w_last;

  // Finish on the last digit, or as soon as the slice reports a mismatch:
  // once eq is 0 no lower digit can change the outcome.
  assign w_last = (r_dig == '0) || !bus.slice_EQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_dig   <= '0;
      r_cnt   <= '0;
      r_EQ    <= 1'b0;
      r_GT    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.b;
            r_eq    <= 1'b1;
            r_gt    <= 1'b0;
            r_dig   <= DIG_INIT;
            r_cnt   <= CNT_INIT;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_eq   <= bus.slice_EQ;
            r_gt   <= bus.slice_GT;
            r_a_sr <= r_a_sr << 2;
            r_b_sr <= r_b_sr << 2;
            if (w_last) begin
              r_EQ    <= bus.slice_EQ;
              r_GT    <= bus.slice_GT;
              r_state <= S_DONE;
            end else begin
              r_dig <= r_dig - 1'b1;
              r_cnt <= CNT_INIT;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);
  assign bus.EQ   = r_EQ;
  assign bus.GT   = r_GT;

  // Slice drive comes only from registers so it stays glitch-free and
  // constant across a whole settle window; outside SETTLE it is parked at
  // the neutral cascade value.
  always_comb begin
    bus.slice_a  = 2'b00;
    bus.slice_b  = 2'b00;
    bus.slice_eq = 1'b1;
    bus.slice_gt = 1'b0;
    if (r_state == S_SETTLE) begin
      bus.slice_a  = r_a_sr[WIDTH-1 -: 2];
      bus.slice_b  = r_b_sr[WIDTH-1 -: 2];
      bus.slice_eq = r_eq;
      bus.slice_gt = r_gt;
    end
  end
endmodule

// File: tb/tb_serial_magnitude_comparator_ctrl.sv
module tb_serial_magnitude_comparator_ctrl;
  localparam int W = 8;
  localparam int D = W / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        start_v = '0;
  logic [2:0][W-1:0] a_v = '0;
  logic [2:0][W-1:0] b_v = '0;
  wire  [2:0]        busy_v, done_v, eqo_v, gto_v, seq_v, sgt_v;
  wire  [2:0][1:0]   sa_v, sb_v;

  int npass = 0;
  int nchk  = 0;
  logic [1:0] q [3][$];
  logic [1:0] prev [3];

  // Three instances: settle windows of 3 (directed), 1 and 4 (random).
  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int S = (g == 0) ? 3 : ((g == 1) ? 1 : 4);
    serial_magnitude_comparator_ctrl_if #(.WIDTH(W)) bus ();
    assign bus.start    = start_v[g];
    assign bus.a        = a_v[g];
    assign bus.b        = b_v[g];
    // behavioural 2-bit cascadable slice
    assign bus.slice_EQ = bus.slice_eq & (bus.slice_a == bus.slice_b);
    assign bus.slice_GT = bus.slice_gt | (bus.slice_eq & (bus.slice_a > bus.slice_b));
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign eqo_v[g]  = bus.EQ;
    assign gto_v[g]  = bus.GT;
    assign seq_v[g]  = bus.slice_eq;
    assign sgt_v[g]  = bus.slice_gt;
    assign sa_v[g]   = bus.slice_a;
    assign sb_v[g]   = bus.slice_b;
    serial_magnitude_comparator_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
  end

  function automatic int s_of(input int k);
    return (k == 0) ? 3 : ((k == 1) ? 1 : 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input int k, input string tag);
    chk({tag, "_busy"}, 32'(busy_v[k]), 32'd0);
    chk({tag, "_done"}, 32'(done_v[k]), 32'd0);
    chk({tag, "_sa"},   32'(sa_v[k]),   32'd0);
    chk({tag, "_sb"},   32'(sb_v[k]),   32'd0);
    chk({tag, "_seq"},  32'(seq_v[k]),  32'd1);
    chk({tag, "_sgt"},  32'(sgt_v[k]),  32'd0);
  endtask

  // One full compare on instance k. Expected result goes to the scoreboard
  // at accept and is popped when done appears.
  task automatic compare(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit slices, input bit poke);
    int S, kd, lat, n, d;
    bit seen;
    logic [1:0] got;
    S = s_of(k);
    n = 0;
    while (busy_v[k] && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    a_v[k] = a; b_v[k] = b; start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    a_v[k] = ~a; b_v[k] = a ^ b;      // operands must already be latched
    q[k].push_back({a == b, a > b});
    kd = D;
    for (int i = 0; i < D; i++) begin
      if (a[W-1-2*i -: 2] != b[W-1-2*i -: 2]) begin kd = i + 1; break; end
    end
    lat = kd * S;
    seen = 1'b0;
    n = 0;
    while (!seen && n < lat + 10) begin
      @(negedge clk);
      n++;
      if (poke) start_v[k] = (n == 2 || n == lat + 1);
      if (done_v[k]) seen = 1'b1;
      else begin
        chk("busy", 32'(busy_v[k]), 32'd1);
        chk("hold_result", 32'({eqo_v[k], gto_v[k]}), 32'(prev[k]));
        if (slices) begin
          d = (n - 1) / S;
          chk("slice_a",  32'(sa_v[k]),  32'(a[W-1-2*d -: 2]));
          chk("slice_b",  32'(sb_v[k]),  32'(b[W-1-2*d -: 2]));
          chk("slice_eq", 32'(seq_v[k]), 32'd1);
          chk("slice_gt", 32'(sgt_v[k]), 32'd0);
        end
      end
    end
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      void'(q[k].pop_front());
    end else begin
      chk("latency", n - 1, lat);
      got = q[k].pop_front();
      chk("result", 32'({eqo_v[k], gto_v[k]}), 32'(got));
      chk("eq_gt_excl", 32'(eqo_v[k] & gto_v[k]), 32'd0);
      chk("busy_in_done", 32'(busy_v[k]), 32'd1);
      prev[k] = got;
    end
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    @(negedge clk);
    chk("done_width", 32'(done_v[k]), 32'd0);
    chk("busy_idle", 32'(busy_v[k]), 32'd0);
    if (slices) chk_idle_outputs(k, "post");
    if (poke) begin
      @(negedge clk);
      chk("no_queued_start", 32'({busy_v[k], done_v[k]}), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int n;
    for (int k = 0; k < 3; k++) prev[k] = 2'b00;

    // reset state
    repeat (2) @(negedge clk);
    chk_idle_outputs(0, "rst");
    chk("rst_EQ", 32'(eqo_v[0]), 32'd0);
    chk("rst_GT", 32'(gto_v[0]), 32'd0);
    rst_n = 1'b1;

    // directed
    compare(0, 8'hA5, 8'hA5, 1'b1, 1'b0);
    compare(0, 8'h80, 8'h7F, 1'b1, 1'b0);
    compare(0, 8'h12, 8'h13, 1'b1, 1'b0);
    compare(0, 8'h4C, 8'h4D, 1'b1, 1'b1);   // start pokes while busy

    // reset in the middle of a compare
    @(negedge clk);
    a_v[0] = 8'h3C; b_v[0] = 8'h3C; start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs(0, "midrst");
    chk("midrst_EQ", 32'(eqo_v[0]), 32'd0);
    chk("midrst_GT", 32'(gto_v[0]), 32'd0);
    n = 0;
    repeat (3) begin @(negedge clk); if (done_v[0]) n++; end
    chk("midrst_no_done", n, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) prev[k] = 2'b00;
    compare(0, 8'h3C, 8'h3D, 1'b1, 1'b0);
    compare(0, 8'hC3, 8'h3C, 1'b1, 1'b0);

    // randomized on S=1 and S=4
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 500; i++) begin
        ra = W'($urandom);
        case ($urandom_range(0, 3))
          0:       rb = ra;
          1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
          default: rb = W'($urandom);
        endcase
        compare(k, ra, rb, 1'b0, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
